priority_encoder_rr: RTL and testbench

PRIORITY_ENCODER_RR -- requirements
Module: priority_encoder_rr

---
 rtl/priority_encoder_rr.sv | 104 ++++++++++
 tb/tb_priority_encoder_rr.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/priority_encoder_rr.sv
// Priority encoder with fixed (LSB- or MSB-first) and round-robin arbitration,
// registered behind a one-deep valid/ready output stage.
module priority_encoder_rr #(
    parameter int N         = 8,
    parameter int MSB_FIRST = 0,
    localparam int W        = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mode,
    input  logic         req_valid,
    input  logic [N-1:0] req,
    output logic         req_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic         out_none,
    output logic         out_multi,
    input  logic         out_ready
);

    logic [W-1:0] ptr;
    logic [W-1:0] win_p0;
    logic [W-1:0] ptr_nxt_p0;
    logic [N-1:0] onehot_p0;
    logic         none_p0;
    logic         multi_p0;
    logic         in_xfer;

    function automatic logic bit_at(input logic [N-1:0] v, input int i);
        logic [N-1:0] s;
        s = v >> i;
        return s[0];
    endfunction

    function automatic logic [W-1:0] fixed_pick(input logic [N-1:0] v);
        logic [W-1:0] idx;
        idx = '0;
        // Later assignments override earlier ones, so scan towards the winning end.
        for (int i = 0; i < N; i++) begin
            if (MSB_FIRST != 0) begin
                if (bit_at(v, i)) idx = W'(i);
            end else begin
                if (bit_at(v, N - 1 - i)) idx = W'(N - 1 - i);
            end
        end
        return idx;
    endfunction

    function automatic logic [W-1:0] rr_pick(input logic [N-1:0] v, input logic [W-1:0] p);
        logic [W-1:0] idx;
        logic         found;
        int           j;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(p) + k;
            if (j >= N) j = j - N;
            if (!found && bit_at(v, j)) begin
                idx   = W'(j);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    assign req_ready = !out_valid || out_ready;
    assign in_xfer   = req_valid && req_ready;

    // Stage p0: combinational encode of the incoming vector
    always_comb begin
        none_p0    = ~|req;
        multi_p0   = |(req & (req - N'(1)));
        win_p0     = '0;
        onehot_p0  = '0;
        if (!none_p0) begin
            win_p0    = mode ? rr_pick(req, ptr) : fixed_pick(req);
            onehot_p0 = N'(1) << win_p0;
        end
        ptr_nxt_p0 = (win_p0 == W'(N - 1)) ? '0 : win_p0 + W'(1);
    end

    // Stage p1: output register and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_idx    <= '0;
            out_onehot <= '0;
            out_none   <= 1'b0;
            out_multi  <= 1'b0;
            ptr        <= '0;
        end else if (in_xfer) begin
            out_valid  <= 1'b1;
            out_idx    <= win_p0;
            out_onehot <= onehot_p0;
            out_none   <= none_p0;
            out_multi  <= multi_p0;
            if (mode && !none_p0) ptr <= ptr_nxt_p0;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_priority_encoder_rr.sv
// Scoreboard bench for priority_encoder_rr: three instances (N=8 LSB-first,
// N=8 MSB-first, N=5) driven in lockstep against a behavioural model.
module tb_priority_encoder_rr;

    typedef struct packed {
        logic [63:0] idx;
        logic [63:0] oh;
        logic [63:0] none;
        logic [63:0] multi;
    } exp_t;

    typedef struct packed {
        exp_t e0;
        exp_t e1;
        exp_t e2;
    } exp_set_t;

    logic       clk;
    logic       rst;
    logic       mode;
    logic       req_valid;
    logic [7:0] req;
    logic       out_ready;

    logic       rdy0, vld0, none0, multi0;
    logic [2:0] idx0;
    logic [7:0] oh0;
    logic       rdy1, vld1, none1, multi1;
    logic [2:0] idx1;
    logic [7:0] oh1;
    logic       rdy2, vld2, none2, multi2;
    logic [2:0] idx2;
    logic [4:0] oh2;

    int       n_checks = 0;
    int       n_fail   = 0;
    exp_set_t sb[$];
    exp_set_t last;
    int       mp[3];

    priority_encoder_rr #(.N(8), .MSB_FIRST(0)) d0 (
        .clk(clk), .rst(rst), .mode(mode), .req_valid(req_valid), .req(req),
        .req_ready(rdy0), .out_valid(vld0), .out_idx(idx0), .out_onehot(oh0),
        .out_none(none0), .out_multi(multi0), .out_ready(out_ready)
    );

    priority_encoder_rr #(.N(8), .MSB_FIRST(1)) d1 (
        .clk(clk), .rst(rst), .mode(mode), .req_valid(req_valid), .req(req),
        .req_ready(rdy1), .out_valid(vld1), .out_idx(idx1), .out_onehot(oh1),
        .out_none(none1), .out_multi(multi1), .out_ready(out_ready)
    );

    priority_encoder_rr #(.N(5), .MSB_FIRST(0)) d2 (
        .clk(clk), .rst(rst), .mode(mode), .req_valid(req_valid), .req(req[4:0]),
        .req_ready(rdy2), .out_valid(vld2), .out_idx(idx2), .out_onehot(oh2),
        .out_none(none2), .out_multi(multi2), .out_ready(out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cmp(input string nm, input exp_t a, input exp_t e);
        check({nm, ".idx"}, a.idx, e.idx);
        check({nm, ".onehot"}, a.oh, e.oh);
        check({nm, ".none"}, a.none, e.none);
        check({nm, ".multi"}, a.multi, e.multi);
    endtask

    function automatic bit bit_set(input logic [7:0] r, input int i);
        logic [7:0] s;
        s = r >> i;
        return s[0];
    endfunction

    function automatic exp_t model(input int n, input bit msb, input logic [7:0] rin,
                                   input logic m, inout int p);
        exp_t       e;
        logic [7:0] r;
        int         cnt;
        int         w;
        int         j;
        r   = rin & 8'((1 << n) - 1);
        cnt = 0;
        w   = -1;
        for (int i = 0; i < n; i++) if (bit_set(r, i)) cnt++;
        if (cnt != 0) begin
            if (m) begin
                for (int k = 0; k < n; k++) begin
                    j = (p + k) % n;
                    if (w < 0 && bit_set(r, j)) w = j;
                end
                p = (w + 1) % n;
            end else if (msb) begin
                for (int i = n - 1; i >= 0; i--) if (w < 0 && bit_set(r, i)) w = i;
            end else begin
                for (int i = 0; i < n; i++) if (w < 0 && bit_set(r, i)) w = i;
            end
        end
        e.idx   = (w < 0) ? 64'd0 : 64'(w);
        e.oh    = (w < 0) ? 64'd0 : (64'd1 << w);
        e.none  = 64'(cnt == 0);
        e.multi = 64'(cnt >= 2);
        return e;
    endfunction

    task automatic cycle(input logic v, input logic [7:0] r, input logic m, input logic ordy);
        exp_set_t s;
        exp_t     a;
        bit       ev;
        req_valid = v;
        req       = r;
        mode      = m;
        out_ready = ordy;
        @(negedge clk);
        ev = (sb.size() != 0);
        check("out_valid0", 64'(vld0), 64'(ev));
        check("out_valid1", 64'(vld1), 64'(ev));
        check("out_valid2", 64'(vld2), 64'(ev));
        check("req_ready", 64'(rdy0), 64'(!ev || ordy));
        check("ptr0", 64'(d0.ptr), 64'(mp[0]));
        check("ptr1", 64'(d1.ptr), 64'(mp[1]));
        check("ptr2", 64'(d2.ptr), 64'(mp[2]));
        s = ev ? sb[0] : last;
        a.idx = 64'(idx0); a.oh = 64'(oh0); a.none = 64'(none0); a.multi = 64'(multi0);
        cmp("n8lsb", a, s.e0);
        a.idx = 64'(idx1); a.oh = 64'(oh1); a.none = 64'(none1); a.multi = 64'(multi1);
        cmp("n8msb", a, s.e1);
        a.idx = 64'(idx2); a.oh = 64'(oh2); a.none = 64'(none2); a.multi = 64'(multi2);
        cmp("n5", a, s.e2);
        if (ev && ordy) last = sb.pop_front();
        if (v && (!ev || ordy) && !rst) begin
            s.e0 = model(8, 1'b0, r, m, mp[0]);
            s.e1 = model(8, 1'b1, r, m, mp[1]);
            s.e2 = model(5, 1'b0, r, m, mp[2]);
            sb.push_back(s);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid0", 64'(vld0), 64'd0);
        check("async_rst_valid2", 64'(vld2), 64'd0);
        check("async_rst_onehot0", 64'(oh0), 64'd0);
        check("async_rst_ptr0", 64'(d0.ptr), 64'd0);
        check("async_rst_ready", 64'(rdy0), 64'd1);
        sb.delete();
        last = '0;
        mp   = '{0, 0, 0};
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] rv;
        rst       = 1'b1;
        mode      = 1'b0;
        req_valid = 1'b0;
        req       = '0;
        out_ready = 1'b1;
        last      = '0;
        mp        = '{0, 0, 0};
        #3;
        check("reset_valid", 64'(vld0), 64'd0);
        check("reset_idx", 64'(idx0), 64'd0);
        check("reset_none", 64'(none0), 64'd0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        #10 rst = 1'b0;

        // Fixed priority both directions, then idle output transfer
        cycle(1'b1, 8'b0010_1100, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        // All-zero in round-robin mode leaves ptr alone
        cycle(1'b1, 8'h00, 1'b1, 1'b1);
        // Round-robin alternation and N=5 wrap
        cycle(1'b1, 8'b1000_0001, 1'b1, 1'b1);
        cycle(1'b1, 8'b1000_0001, 1'b1, 1'b1);
        cycle(1'b1, 8'b1000_0001, 1'b1, 1'b1);
        cycle(1'b1, 8'b0001_0000, 1'b1, 1'b1);
        cycle(1'b1, 8'b0000_0011, 1'b1, 1'b1);
        // Mode switch retains ptr
        cycle(1'b1, 8'b1111_0000, 1'b0, 1'b1);
        cycle(1'b1, 8'b1111_0000, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);

        // Back-pressure with changing req, then release with no bubble
        cycle(1'b1, 8'h0F, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h30 + i), 1'b1, 1'b0);
        cycle(1'b1, 8'h81, 1'b1, 1'b1);
        cycle(1'b1, 8'h42, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);

        for (int i = 0; i < 60; i++) begin
            rv = 8'($urandom);
            if ((i % 7) == 0) rv = 8'h00;
            cycle(1'($urandom_range(0, 1)), rv, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0));
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Reset while a result is held under back-pressure
        cycle(1'b1, 8'h08, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        async_reset();
        cycle(1'b1, 8'h11, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
